// File: rtl/crc_frame_feeder.sv
// Frame front end for the CRC worker: command latch, host FIFO, first/last tagging.
// Define CRC_FEED_TIMEOUT_EN to add a 256-cycle watchdog on the worker done status.
module crc_frame_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_START,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    input  logic                  CMD_POLY,
    output logic                  CMD_BUSY,
    input  logic                  HD_VALID,
    input  logic [DATA_WIDTH-1:0] HD_DATA,
    output logic                  HD_READY,
    output logic                  WK_VALID,
    output logic [DATA_WIDTH-1:0] WK_DATA,
    output logic                  WK_FIRST,
    output logic                  WK_LAST,
    output logic                  WK_POLY,
    input  logic                  WK_READY,
    input  logic                  WK_DONE,
    output logic                  FRM_DONE,
    output logic                  FRM_ERR
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW:0]           r_wr_ptr;
    logic [PW:0]           r_rd_ptr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_in_cnt;
    logic [LEN_WIDTH-1:0]  r_out_cnt;
    logic                  r_poly;
    logic                  r_frm_done;
    logic                  r_frm_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_start_ok;
    logic w_start_bad;
    logic w_timeout;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push  = HD_VALID && HD_READY;
    assign w_pop   = WK_VALID && WK_READY;

    assign w_start_ok  = CMD_START && (r_state == S_IDLE) &&
                         (CMD_LEN != '0);
    assign w_start_bad = CMD_START && ((r_state != S_IDLE) ||
                         (CMD_LEN == '0));

`ifdef CRC_FEED_TIMEOUT_EN
    logic [7:0] r_wd;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wd <= '0;
        end else if (r_state != S_WAIT) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 8'd1;
        end
    end

    // A done arriving on the final cycle still wins over the timeout
    assign w_timeout = (r_state == S_WAIT) && !WK_DONE && (r_wd == 8'hFF);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_pop && WK_LAST) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (WK_DONE || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        CMD_BUSY = (r_state != S_IDLE);
        HD_READY = 1'b0;
        WK_VALID = 1'b0;
        WK_DATA  = '0;
        WK_FIRST = 1'b0;
        WK_LAST  = 1'b0;
        if (r_state == S_STREAM) begin
            HD_READY = !w_full && (r_in_cnt != r_len);
            WK_VALID = !w_empty;
        end
        if (WK_VALID) begin
            WK_DATA  = r_mem[r_rd_ptr[PW-1:0]];
            WK_FIRST = (r_out_cnt == '0);
            WK_LAST  = (r_out_cnt == r_len - LEN_WIDTH'(1));
        end
    end

    assign WK_POLY  = r_poly;
    assign FRM_DONE = r_frm_done;
    assign FRM_ERR  = r_frm_err;

    // Storage needs no reset: WK_DATA is masked while the FIFO is empty
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= HD_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_poly     <= 1'b0;
            r_frm_done <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_frm_done <= (r_state == S_WAIT) && WK_DONE;
            if (w_start_ok) begin
                r_len     <= CMD_LEN;
                r_poly    <= CMD_POLY;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_frm_err <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
                    r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
                end
                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + (PW+1)'(1);
                    r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
                end
                if (w_start_bad || w_timeout) begin
                    r_frm_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_crc_frame_feeder.sv
// Directed bench for crc_frame_feeder: cycle table for a basic frame,
// hand-written sequences for backpressure, errors, reset and watchdog.
module tb_crc_frame_feeder;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_START;
    logic [15:0] CMD_LEN;
    logic        CMD_POLY;
    logic        CMD_BUSY;
    logic        HD_VALID;
    logic [31:0] HD_DATA;
    logic        HD_READY;
    logic        WK_VALID;
    logic [31:0] WK_DATA;
    logic        WK_FIRST;
    logic        WK_LAST;
    logic        WK_POLY;
    logic        WK_READY;
    logic        WK_DONE;
    logic        FRM_DONE;
    logic        FRM_ERR;

    crc_frame_feeder #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .LEN_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CMD_START(CMD_START),
        .CMD_LEN(CMD_LEN),
        .CMD_POLY(CMD_POLY),
        .CMD_BUSY(CMD_BUSY),
        .HD_VALID(HD_VALID),
        .HD_DATA(HD_DATA),
        .HD_READY(HD_READY),
        .WK_VALID(WK_VALID),
        .WK_DATA(WK_DATA),
        .WK_FIRST(WK_FIRST),
        .WK_LAST(WK_LAST),
        .WK_POLY(WK_POLY),
        .WK_READY(WK_READY),
        .WK_DONE(WK_DONE),
        .FRM_DONE(FRM_DONE),
        .FRM_ERR(FRM_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        start;
        logic [15:0] len;
        logic        poly;
        logic        hv;
        logic [31:0] hd;
        logic        wr;
        logic        wd;
        logic        busy;
        logic        hrdy;
        logic        wv;
        logic [31:0] wdata;
        logic        first;
        logic        last;
        logic        wpoly;
        logic        done;
        logic        err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          n_push;
    int          host_n;
    logic [31:0] host_w [16];
    logic [31:0] pop_data [$];
    logic        pop_first [$];
    logic        pop_last [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic p;
        logic q;
        p = HD_VALID && HD_READY;
        q = WK_VALID && WK_READY;
        if (q) begin
            pop_data.push_back(WK_DATA);
            pop_first.push_back(WK_FIRST);
            pop_last.push_back(WK_LAST);
        end
        @(posedge CLK);
        #1;
        if (p) n_push++;
    endtask

    task automatic host_reset(input int n);
        n_push = 0;
        host_n = n;
        pop_data.delete();
        pop_first.delete();
        pop_last.delete();
    endtask

    task automatic feed_cycle();
        HD_VALID = (n_push < host_n);
        HD_DATA  = HD_VALID ? host_w[n_push] : 32'h0;
        tick();
    endtask

    task automatic start_frame(input logic [15:0] len, input logic poly);
        HD_VALID  = 1'b0;
        CMD_START = 1'b1;
        CMD_LEN   = len;
        CMD_POLY  = poly;
        tick();
        CMD_START = 1'b0;
        CMD_LEN   = 16'h0;
        CMD_POLY  = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        HD_VALID = 1'b0;
        WK_DONE  = 1'b1;
        tick();
        WK_DONE  = 1'b0;
        chk({name, " done"}, 32'(FRM_DONE), 32'd1);
        chk({name, " busy"}, 32'(CMD_BUSY), 32'd0);
        tick();
        chk({name, " done pulse"}, 32'(FRM_DONE), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " busy"},  32'(CMD_BUSY), 32'd0);
        chk({name, " hrdy"},  32'(HD_READY), 32'd0);
        chk({name, " wv"},    32'(WK_VALID), 32'd0);
        chk({name, " wdata"}, WK_DATA,       32'd0);
        chk({name, " first"}, 32'(WK_FIRST), 32'd0);
        chk({name, " last"},  32'(WK_LAST),  32'd0);
        chk({name, " wpoly"}, 32'(WK_POLY),  32'd0);
        chk({name, " done"},  32'(FRM_DONE), 32'd0);
        chk({name, " err"},   32'(FRM_ERR),  32'd0);
    endtask

    vec_t tbl [12];

    initial begin
        RST       = 1'b1;
        CMD_START = 1'b0;
        CMD_LEN   = 16'h0;
        CMD_POLY  = 1'b0;
        HD_VALID  = 1'b0;
        HD_DATA   = 32'h0;
        WK_READY  = 1'b0;
        WK_DONE   = 1'b0;
        host_reset(0);

        tbl[0]  = '{1, 3, 1, 0, 32'h0,        0, 0,
                    1, 1, 0, 32'h0,        0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 32'h11111111, 1, 0,
                    1, 1, 1, 32'h11111111, 1, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 32'h22222222, 1, 0,
                    1, 1, 1, 32'h22222222, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 32'h33333333, 1, 0,
                    1, 0, 1, 32'h33333333, 0, 1, 1, 0, 0};
        for (int i = 4; i < 9; i++) begin
            tbl[i] = '{0, 0, 0, 0, 32'h0, 1, 0,
                       1, 0, 0, 32'h0, 0, 0, 1, 0, 0};
        end
        tbl[9]  = '{0, 0, 0, 0, 32'h0, 1, 1,
                    0, 0, 0, 32'h0, 0, 0, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 32'h0, 1, 0,
                    0, 0, 0, 32'h0, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 32'h0, 1, 1,
                    0, 0, 0, 32'h0, 0, 0, 1, 0, 0};

        // reset state
        repeat (2) tick();
        chk_all_zero("reset");
        RST = 1'b0;
        tick();

        // basic frame, one row per cycle
        for (int i = 0; i < 12; i++) begin
            CMD_START = tbl[i].start;
            CMD_LEN   = tbl[i].len;
            CMD_POLY  = tbl[i].poly;
            HD_VALID  = tbl[i].hv;
            HD_DATA   = tbl[i].hd;
            WK_READY  = tbl[i].wr;
            WK_DONE   = tbl[i].wd;
            tick();
            chk($sformatf("row%0d busy", i),  32'(CMD_BUSY), 32'(tbl[i].busy));
            chk($sformatf("row%0d hrdy", i),  32'(HD_READY), 32'(tbl[i].hrdy));
            chk($sformatf("row%0d wv", i),    32'(WK_VALID), 32'(tbl[i].wv));
            chk($sformatf("row%0d wdata", i), WK_DATA,       tbl[i].wdata);
            chk($sformatf("row%0d first", i), 32'(WK_FIRST), 32'(tbl[i].first));
            chk($sformatf("row%0d last", i),  32'(WK_LAST),  32'(tbl[i].last));
            chk($sformatf("row%0d wpoly", i), 32'(WK_POLY),  32'(tbl[i].wpoly));
            chk($sformatf("row%0d done", i),  32'(FRM_DONE), 32'(tbl[i].done));
            chk($sformatf("row%0d err", i),   32'(FRM_ERR),  32'(tbl[i].err));
        end
        CMD_START = 1'b0;
        WK_DONE   = 1'b0;
        HD_VALID  = 1'b0;

        // backpressure: worker stalled for 10 cycles, then released
        for (int i = 0; i < 8; i++) host_w[i] = 32'(i + 1);
        start_frame(16'd8, 1'b0);
        host_reset(8);
        WK_READY = 1'b0;
        repeat (10) feed_cycle();
        chk("bp accepts", 32'(n_push), 32'd4);
        chk("bp hrdy", 32'(HD_READY), 32'd0);
        chk("bp wv", 32'(WK_VALID), 32'd1);
        chk("bp hold data", WK_DATA, 32'h1);
        chk("bp hold first", 32'(WK_FIRST), 32'd1);
        chk("bp wpoly", 32'(WK_POLY), 32'd0);
        WK_READY = 1'b1;
        for (int c = 0; c < 40 && pop_data.size() < 8; c++) feed_cycle();
        chk("bp pops", 32'(pop_data.size()), 32'd8);
        for (int i = 0; i < pop_data.size(); i++) begin
            chk($sformatf("bp data%0d", i), pop_data[i], 32'(i + 1));
            chk($sformatf("bp first%0d", i), 32'(pop_first[i]), 32'(i == 0));
            chk($sformatf("bp last%0d", i), 32'(pop_last[i]), 32'(i == 7));
        end
        chk("bp busy wait", 32'(CMD_BUSY), 32'd1);
        finish_frame("bp");

        // over-supply: 4 words offered to a 2-word frame
        for (int i = 0; i < 4; i++) host_w[i] = 32'hA0 + 32'(i);
        start_frame(16'd2, 1'b1);
        host_reset(4);
        repeat (6) feed_cycle();
        chk("os accepts", 32'(n_push), 32'd2);
        chk("os hrdy", 32'(HD_READY), 32'd0);
        chk("os pops", 32'(pop_data.size()), 32'd2);
        finish_frame("os");

        // command errors
        CMD_START = 1'b1;
        CMD_LEN   = 16'd0;
        tick();
        CMD_START = 1'b0;
        chk("len0 err", 32'(FRM_ERR), 32'd1);
        chk("len0 busy", 32'(CMD_BUSY), 32'd0);
        tick();
        chk("len0 busy2", 32'(CMD_BUSY), 32'd0);
        start_frame(16'd1, 1'b0);
        chk("restart err clr", 32'(FRM_ERR), 32'd0);
        chk("restart busy", 32'(CMD_BUSY), 32'd1);
        CMD_START = 1'b1;
        CMD_LEN   = 16'd5;
        CMD_POLY  = 1'b1;
        tick();
        CMD_START = 1'b0;
        chk("mid err", 32'(FRM_ERR), 32'd1);
        chk("mid poly kept", 32'(WK_POLY), 32'd0);
        host_w[0] = 32'h5A5A5A5A;
        host_reset(1);
        for (int c = 0; c < 10 && pop_data.size() < 1; c++) feed_cycle();
        chk("mid pops", 32'(pop_data.size()), 32'd1);
        if (pop_data.size() == 1) begin
            chk("mid data", pop_data[0], 32'h5A5A5A5A);
            chk("mid first", 32'(pop_first[0]), 32'd1);
            chk("mid last", 32'(pop_last[0]), 32'd1);
        end
        finish_frame("mid");
        chk("mid err sticky", 32'(FRM_ERR), 32'd1);

        // reset in the middle of a 5-word frame
        for (int i = 0; i < 5; i++) host_w[i] = 32'hC0 + 32'(i);
        start_frame(16'd5, 1'b1);
        host_reset(5);
        for (int c = 0; c < 20 && pop_data.size() < 2; c++) feed_cycle();
        chk("rst pops before", 32'(pop_data.size()), 32'd2);
        RST = 1'b1;
        #1;
        chk_all_zero("async rst");
        HD_VALID = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        chk("post rst done", 32'(FRM_DONE), 32'd0);
        host_w[0] = 32'hAB;
        start_frame(16'd1, 1'b0);
        host_reset(1);
        for (int c = 0; c < 10 && pop_data.size() < 1; c++) feed_cycle();
        chk("len1 pops", 32'(pop_data.size()), 32'd1);
        if (pop_data.size() == 1) begin
            chk("len1 data", pop_data[0], 32'hAB);
            chk("len1 first", 32'(pop_first[0]), 32'd1);
            chk("len1 last", 32'(pop_last[0]), 32'd1);
        end
        finish_frame("len1");

`ifdef CRC_FEED_TIMEOUT_EN
        begin
            int seen_done;
            seen_done = 0;
            host_w[0] = 32'h77;
            start_frame(16'd1, 1'b0);
            host_reset(1);
            for (int c = 0; c < 10 && pop_data.size() < 1; c++) feed_cycle();
            chk("wd pops", 32'(pop_data.size()), 32'd1);
            for (int c = 0; c < 255; c++) begin
                feed_cycle();
                if (FRM_DONE) seen_done++;
            end
            chk("wd busy255", 32'(CMD_BUSY), 32'd1);
            chk("wd err255", 32'(FRM_ERR), 32'd0);
            feed_cycle();
            if (FRM_DONE) seen_done++;
            chk("wd busy", 32'(CMD_BUSY), 32'd0);
            chk("wd err", 32'(FRM_ERR), 32'd1);
            feed_cycle();
            if (FRM_DONE) seen_done++;
            chk("wd no done", 32'(seen_done), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
